// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at mid-period,
// and presents each byte with a one-cycle valid strobe or a framing-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_p_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          framing_err_q;
    logic          busy_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_p_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            rx_p_q    <= rx_s_q;
        end
    end

    // Receive FSM with registered strobes, data and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // A held-low line gives no edge, so a break cannot retrigger.
                    if (rx_p_q && !rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s_q, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s_q) begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            framing_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serialiser drives frames and a
// frame-level model predicts each strobe's cycle, data and kind.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        v;
        logic        fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       busy;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  obs[$];
    ev_t  exp[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .framing_err(framing_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe, one entry per high cycle, with the cycle it appeared.
    always @(negedge clk) begin
        if (rx_valid || framing_err) obs.push_back({cyc[31:0], rx_data, rx_valid, framing_err});
    end

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t);
        t = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Frame-level model: strobe appears 3 sync cycles + half a bit + nine bits after the start edge.
    task automatic model_frame(input int t, input logic [7:0] b, input logic stop);
        ev_t e;
        e.cyc  = 32'(t + 3 + CPB / 2 + 9 * CPB);
        e.v    = stop;
        e.fe   = ~stop;
        if (stop) last_good = b;
        e.data = last_good;
        exp.push_back(e);
    endtask

    task automatic clear_q();
        obs.delete();
        exp.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        vectors++; if (framing_err !== 1'b0) begin miscompares++; $display("FAIL reset_fe got %b want 0", framing_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_nominal();
        int t;
        clear_q();
        send_frame(8'hAD, 1'b1, t);
        model_frame(t, 8'hAD, 1'b1);
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL nominal_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL nominal_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        clear_q();
        rx_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) rx_in = 1'b1;
            @(posedge clk); #1;
            if (busy === 1'b1) busy_cnt++;
        end
        vectors++; if (busy_cnt !== 8) begin miscompares++; $display("FAIL glitch_busy got %0d cycles want 8", busy_cnt); end
        vectors++; if (obs.size() !== 0) begin miscompares++; $display("FAIL glitch_pulses got %0d want 0", obs.size()); end
        vectors++; if (rx_data !== last_good) begin miscompares++; $display("FAIL glitch_data got %h want %h", rx_data, last_good); end
    endtask

    task automatic test_framing();
        int t;
        int busy_cnt = 0;
        clear_q();
        send_frame(8'h55, 1'b0, t);
        model_frame(t, 8'h55, 1'b0);
        for (int i = 0; i < 2 * CPB; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_cnt++;
        end
        vectors++; if (busy_cnt !== 0) begin miscompares++; $display("FAIL break_restart got %0d busy cycles want 0", busy_cnt); end
        vectors++; if (rx_data !== 8'hAD) begin miscompares++; $display("FAIL fe_data_hold got %h want ad", rx_data); end
        idle(20);
        send_frame(8'h12, 1'b1, t);
        model_frame(t, 8'h12, 1'b1);
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL framing_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL framing_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_q();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        model_frame(t0, 8'h00, 1'b1);
        model_frame(t1, 8'hFF, 1'b1);
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
        if (obs.size() == 2) begin
            vectors++;
            if (obs[1].cyc - obs[0].cyc !== 32'd160) begin miscompares++; $display("FAIL b2b_spacing got %0d want 160", obs[1].cyc - obs[0].cyc); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        logic [7:0] b = 8'hA5;
        clear_q();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_in = b[4];
        repeat (CPB / 2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL midrst_data got %h want 00", rx_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
        vectors++; if ({rx_valid, framing_err} !== 2'b00) begin miscompares++; $display("FAIL midrst_strobes got %b want 00", {rx_valid, framing_err}); end
        last_good = 8'h00;
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        send_frame(8'h3C, 1'b1, t);
        model_frame(t, 8'h3C, 1'b1);
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL midrst_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL midrst_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
    endtask

    task automatic test_loopback();
        int t;
        logic [7:0] bytes [3] = '{8'h01, 8'h80, 8'hC3};
        clear_q();
        for (int i = 0; i < 3; i++) begin
            send_frame(bytes[i], 1'b1, t);
            model_frame(t, bytes[i], 1'b1);
        end
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL loop_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL loop_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
    endtask

    task automatic test_random();
        int t;
        logic [7:0] b;
        logic stop;
        clear_q();
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(3, 0) != 0);
            send_frame(b, stop, t);
            model_frame(t, b, stop);
            if (!stop || $urandom_range(1, 0) == 1) idle(4 + $urandom_range(20, 0));
        end
        idle(4);
        vectors++; if (obs.size() !== exp.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin miscompares++; $display("FAIL rand_ev%0d got cyc=%0d d=%h v=%b fe=%b want cyc=%0d d=%h v=%b fe=%b", i, obs[i].cyc, obs[i].data, obs[i].v, obs[i].fe, exp[i].cyc, exp[i].data, exp[i].v, exp[i].fe); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver; the receive-side counterpart of the `tx_piso` transmit path. It recovers 8N1 frames from an asynchronous serial line, idle high, one start bit, 8 data bits LSB first, one stop bit. Each complete byte is presented on a parallel bus with a one-cycle valid strobe, and a bad stop bit is flagged as a framing error. It sits between the pad-side serial input and the host-side byte consumer, which has no backpressure.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx_in` input 1: serial line. It is asynchronous to `clk` and idles high.
- `rx_data` output 8: last correctly framed byte. It holds its value until the next valid frame.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `framing_err` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `rx_in` passes through a 2-flop synchroniser, giving `rx_s`, and one further flop, giving `rx_p`, for edge detection. All three flops reset to 1.
- **Bit counter:** `cnt`, width clog2(`CLKS_PER_BIT`). It resets to 0 on every state entry.
- **Bit index:** `bit_idx`, 3 bits.
- **Shift register:** `shreg`, 8 bits, shifts right. Each sampled bit enters at bit 7, so after 8 bits the LSB-first byte is aligned.
- **IDLE:** a falling edge (`rx_p`=1, `rx_s`=0) moves the FSM to START. A line held low (break) never retriggers, because a new edge is required.
- **START:**
  - When `cnt` = `CLKS_PER_BIT`/2−1, sample `rx_s`.
  - If the sample is 0, go to DATA with `bit_idx`=0.
  - If the sample is 1, treat it as a glitch and return to IDLE with no output pulse.
- **DATA:**
  - When `cnt` = `CLKS_PER_BIT`−1, shift `rx_s` into `shreg`.
  - If `bit_idx`=7, go to STOP; otherwise increment `bit_idx` and stay in DATA.
- **STOP:** when `cnt` = `CLKS_PER_BIT`−1, sample `rx_s`.
  - If 1: register `rx_data`←`shreg` and pulse `rx_valid`.
  - If 0: pulse `framing_err` and leave `rx_data` unchanged.
  - In both cases go to IDLE.
- `rx_valid` and `framing_err` are registered and never high together.
- There is no overrun detection. A consumer that misses a pulse loses the byte.
- **Reset (any time, including mid-frame):**
  - State returns to IDLE; `cnt`, `bit_idx` and `shreg` go to 0.
  - `rx_data` goes to 0x00; `rx_valid`, `framing_err` and `busy` go to 0.
  - Synchroniser flops go to 1.

## Timing
- Let E0 be the clock edge at which the FSM enters START. This is 3 edges after `rx_in` falls, due to synchroniser plus edge-detect latency.
- The start bit is checked at edge E0+`CLKS_PER_BIT`/2, i.e. mid-bit.
- Data bit k (k=0..7) is sampled at edge E0+`CLKS_PER_BIT`/2+(k+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at edge E0+`CLKS_PER_BIT`/2+9·`CLKS_PER_BIT`. The FSM is in IDLE at that same edge, and `rx_valid`/`framing_err` are high for the following cycle only.
- `busy` rises at E0 and falls at the stop-sample edge (or at the glitch-abort edge).
- **Back-to-back frames:** IDLE is re-entered half a bit before the stop bit ends, so a start edge immediately after the stop bit is accepted with no gap.
- **Tolerance:** the receiver tolerates about ±4% baud mismatch, as it samples mid-bit.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 with stimulus bit period = 16 clocks.
- **Nominal frame:** after reset release, send 0xAD (LSB first: 1,0,1,1,0,1,0,1) with stop=1. Require:
  - `rx_valid` pulses exactly once, 1 cycle wide, at E0+152;
  - `rx_data`=0xAD;
  - `framing_err`=0 throughout.
- **Glitch rejection:** drive `rx_in` low for 3 clocks, then high. Require:
  - `busy` high for 8 cycles, then low;
  - no `rx_valid`, no `framing_err`;
  - `rx_data` unchanged.
- **Framing error:** after a good 0xAD, send 0x55 with stop bit 0 and hold the line low for 2 bit times. Require:
  - one `framing_err` pulse;
  - `rx_data` stays 0xAD;
  - no restart while the line is held low.
  
  Then release the line high and send 0x12. Require `rx_valid` with `rx_data`=0x12.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Require two `rx_valid` pulses 160 cycles apart, with `rx_data` reading 0x00 then 0xFF.
- **Reset mid-frame:** assert `reset` low during data bit 4 of frame 0xA5. Require:
  - all outputs 0 immediately, i.e. asynchronously;
  - after release with the line idle, frame 0x3C gives `rx_valid` with `rx_data`=0x3C.
- **Loopback:** connect `tx_piso` to `rx_in` with matching bit timing, and drive 0x01, 0x80, 0xC3. Require each byte to be received in order with no errors.
